// File: rtl/vram_line_fetcher.sv
// VRAM line fetcher: streams one scanline from the single-port VRAM into a small pixel FIFO
// and slots CPU byte writes into the RAM cycles that the fetch leaves unused.
module vram_line_fetcher #(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_start,
    input  logic [14:0]          line_base,
    input  logic [LEN_WIDTH-1:0] line_length,
    output logic                 busy,
    output logic                 line_done,
    output logic [7:0]           pixel_data,
    output logic                 pixel_valid,
    input  logic                 pixel_ready,
    input  logic                 cpu_write_req,
    input  logic [14:0]          cpu_addr,
    input  logic [7:0]           cpu_data,
    output logic                 cpu_write_ack,
    output logic [14:0]          ram_addr,
    output logic                 ram_write_enable,
    output logic [7:0]           ram_data_in,
    input  logic [7:0]           ram_data_out
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [14:0]          fetch_addr_q, fetch_addr_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 inflight_q, inflight_d;
    logic                 line_done_q, line_done_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [7:0]           fifo_mem_q [FIFO_DEPTH];
    logic [7:0]           fifo_mem_d [FIFO_DEPTH];

    logic                 start;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 grant;
    logic [CNT_W-1:0]     count_after_pop;

    // A restart wins over everything: the pop is lost with the flush and the returning
    // read belongs to the abandoned line, so it is simply not pushed.
    assign start           = line_start && !reset;
    assign pop             = pixel_valid && pixel_ready && !start;
    assign push            = inflight_q && !start;
    assign count_after_pop = count_q - CNT_W'(pop);

    assign busy        = (state_q != IDLE);
    assign line_done   = line_done_q;
    assign pixel_valid = (count_q != '0);
    assign pixel_data  = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (line_length == '0) ? IDLE : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (issue && (remaining_q == LEN_WIDTH'(1))) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (push) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // A read is only issued when a FIFO slot is reserved for it, counting the read
    // already in flight, so a returning byte always has somewhere to go.
    always_comb begin
        issue = !reset && !start && (state_q == FETCH) && (remaining_q != '0) &&
                ((count_after_pop + CNT_W'(inflight_q)) < DEPTH_C);
        grant = !reset && !start && !issue && cpu_write_req;

        ram_addr         = fetch_addr_q;
        ram_write_enable = 1'b0;
        ram_data_in      = 8'h00;
        if (grant) begin
            ram_addr         = cpu_addr;
            ram_write_enable = 1'b1;
            ram_data_in      = cpu_data;
        end
        cpu_write_ack = grant;
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        remaining_d  = remaining_q;
        inflight_d   = issue;
        line_done_d  = (state_q == DRAIN) && push;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        fifo_mem_d   = fifo_mem_q;

        if (start) begin
            fetch_addr_d = line_base;
            remaining_d  = line_length;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            line_done_d  = (line_length == '0);
        end else begin
            if (issue) begin
                fetch_addr_d = fetch_addr_q + 15'd1;
                remaining_d  = remaining_q - LEN_WIDTH'(1);
            end
            if (push) begin
                fifo_mem_d[wr_ptr_q] = ram_data_out;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_after_pop + CNT_W'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr_q <= '0;
            remaining_q  <= '0;
            inflight_q   <= 1'b0;
            line_done_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            remaining_q  <= remaining_d;
            inflight_q   <= inflight_d;
            line_done_q  <= line_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage holds only data; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

endmodule

// File: tb/tb_vram_line_fetcher.sv
// Bench for vram_line_fetcher: a VRAM model plus a shadow memory predicts every streamed byte;
// hand sequences cover stream timing, wrap, stall with CPU write, restart, empty line and reset.
module tb_vram_line_fetcher;
    localparam int FIFO_DEPTH = 8;
    localparam int LEN_WIDTH  = 8;

    typedef struct {
        logic [14:0] base;
        int          len;
        bit          cpu_traffic;
        int          exp_bytes;
        logic [14:0] exp_end_addr;
    } line_vec_t;

    logic                 clk;
    logic                 reset;
    logic                 line_start;
    logic [14:0]          line_base;
    logic [LEN_WIDTH-1:0] line_length;
    logic                 busy;
    logic                 line_done;
    logic [7:0]           pixel_data;
    logic                 pixel_valid;
    logic                 pixel_ready;
    logic                 cpu_write_req;
    logic [14:0]          cpu_addr;
    logic [7:0]           cpu_data;
    logic                 cpu_write_ack;
    logic [14:0]          ram_addr;
    logic                 ram_write_enable;
    logic [7:0]           ram_data_in;
    logic [7:0]           ram_data_out;

    logic [7:0] vram   [0:32767];
    logic [7:0] golden [0:32767];
    logic [7:0] pop_q  [$];
    int         ld_count;
    int         total;
    int         bad;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    vram_line_fetcher #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .line_start      (line_start),
        .line_base       (line_base),
        .line_length     (line_length),
        .busy            (busy),
        .line_done       (line_done),
        .pixel_data      (pixel_data),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .cpu_write_req   (cpu_write_req),
        .cpu_addr        (cpu_addr),
        .cpu_data        (cpu_data),
        .cpu_write_ack   (cpu_write_ack),
        .ram_addr        (ram_addr),
        .ram_write_enable(ram_write_enable),
        .ram_data_in     (ram_data_in),
        .ram_data_out    (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port VRAM with one edge of read latency.
    always @(posedge clk) begin
        if (ram_write_enable) begin
            vram[ram_addr] <= ram_data_in;
        end
        ram_data_out <= vram[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Mid-cycle observer: collects popped bytes and line_done pulses and checks the
    // write-port handshake and head stability every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (pixel_valid && pixel_ready && !line_start) begin
                pop_q.push_back(pixel_data);
            end
            if (line_done) begin
                ld_count++;
            end
            if (cpu_write_ack) begin
                checkOutput("ack_req", cpu_write_req, 1);
                checkOutput("ack_we", ram_write_enable, 1);
                checkOutput("ack_addr", ram_addr, cpu_addr);
                checkOutput("ack_data", ram_data_in, cpu_data);
            end else begin
                checkOutput("no_ack_we", ram_write_enable, 0);
            end
            if (prev_hold && pixel_valid) begin
                checkOutput("head_stable", pixel_data, prev_data);
            end
        end
        prev_hold <= pixel_valid && !pixel_ready && !line_start && !reset;
        prev_data <= pixel_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startLine(input logic [14:0] base, input int len);
        line_base   = base;
        line_length = LEN_WIDTH'(len);
        line_start  = 1'b1;
        step();
        line_start  = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        bit done;
        done = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (!busy && !pixel_valid && ld_count >= 1) begin
                done = 1'b1;
                break;
            end
            step();
        end
        checkOutput("idle_within_bound", 32'(done), 1);
        step();
    endtask

    task automatic checkStream(input string name, input logic [14:0] base, input int len);
        checkOutput({name, "_count"}, pop_q.size(), len);
        for (int i = 0; i < len && i < pop_q.size(); i++) begin
            checkOutput(name, pop_q[i], golden[base + 15'(i)]);
        end
    endtask

    task automatic applyStimulus(input line_vec_t v);
        bit finished;
        bit ack_seen;
        finished = 1'b0;
        pop_q.delete();
        ld_count    = 0;
        pixel_ready = 1'($urandom_range(0, 1));
        startLine(v.base, v.len);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ack_seen = cpu_write_ack;
            if (cpu_write_ack) begin
                golden[cpu_addr] = cpu_data;
            end
            if (!busy && !pixel_valid && !cpu_write_req && ld_count >= 1 &&
                pop_q.size() >= v.exp_bytes) begin
                finished = 1'b1;
                break;
            end
            step();
            if (ack_seen) begin
                cpu_write_req = 1'b0;
            end else if (v.cpu_traffic && !cpu_write_req && $urandom_range(0, 3) == 0) begin
                cpu_write_req = 1'b1;
                cpu_addr      = 15'h6000 + 15'($urandom_range(0, 254));
                cpu_data      = 8'($urandom);
            end
            pixel_ready = ($urandom_range(0, 3) != 0);
        end
        checkOutput("line_finished", 32'(finished), 1);
        checkOutput("line_done_count", ld_count, 1);
        checkOutput("end_addr", ram_addr, v.exp_end_addr);
        checkStream("stream", v.base, v.exp_bytes);
        step();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        line_vec_t   vecs [8];
        logic [14:0] wrap_exp [4];
        logic [7:0]  rnd;
        bit          got;

        total = 0;
        bad = 0;
        ld_count = 0;
        reset = 1'b1;
        line_start = 1'b0;
        line_base = '0;
        line_length = '0;
        pixel_ready = 1'b0;
        cpu_write_req = 1'b0;
        cpu_addr = '0;
        cpu_data = '0;

        for (int a = 0; a < 32768; a++) begin
            rnd = 8'($urandom);
            vram[a] = rnd;
            golden[a] = rnd;
        end

        vecs[0] = '{15'h1000, 12, 1'b1, 12, 15'h100C};
        vecs[1] = '{15'h7FF0, 40, 1'b1, 40, 15'h0018};
        vecs[2] = '{15'h0000, 255, 1'b1, 255, 15'h00FF};
        vecs[3] = '{15'h2345, 0, 1'b1, 0, 15'h2345};
        vecs[4] = '{15'h3000, 1, 1'b1, 1, 15'h3001};
        vecs[5] = '{15'h4ABC, 33, 1'b1, 33, 15'h4ADD};
        vecs[6] = '{15'h5000, 9, 1'b0, 9, 15'h5009};
        vecs[7] = '{15'h6000, 255, 1'b0, 255, 15'h60FF};

        wrap_exp[0] = 15'h7FFE;
        wrap_exp[1] = 15'h7FFF;
        wrap_exp[2] = 15'h0000;
        wrap_exp[3] = 15'h0001;

        // Reset state, with a CPU request pending that must not be granted.
        cpu_write_req = 1'b1;
        cpu_addr = 15'h1111;
        cpu_data = 8'h5A;
        repeat (3) step();
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_line_done", line_done, 0);
        checkOutput("rst_pixel_valid", pixel_valid, 0);
        checkOutput("rst_ack", cpu_write_ack, 0);
        checkOutput("rst_we", ram_write_enable, 0);
        checkOutput("rst_addr", ram_addr, 0);
        checkOutput("rst_data_in", ram_data_in, 0);
        step();
        cpu_write_req = 1'b0;
        reset = 1'b0;

        // Basic stream with exact issue and line_done timing.
        vram[15'h0100] = 8'h11; golden[15'h0100] = 8'h11;
        vram[15'h0101] = 8'h22; golden[15'h0101] = 8'h22;
        vram[15'h0102] = 8'h33; golden[15'h0102] = 8'h33;
        vram[15'h0103] = 8'h44; golden[15'h0103] = 8'h44;
        vram[15'h0104] = 8'h55; golden[15'h0104] = 8'h55;
        pixel_ready = 1'b1;
        pop_q.delete();
        ld_count = 0;
        startLine(15'h0100, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("basic_addr", ram_addr, 15'h0100 + 15'(i));
            checkOutput("basic_read", ram_write_enable, 0);
            checkOutput("basic_busy", busy, 1);
            step();
        end
        @(negedge clk);
        checkOutput("basic_done_early", line_done, 0);
        checkOutput("basic_busy_tail", busy, 1);
        step();
        @(negedge clk);
        checkOutput("basic_done_pulse", line_done, 1);
        checkOutput("basic_busy_off", busy, 0);
        step();
        @(negedge clk);
        checkOutput("basic_done_once", line_done, 0);
        step();
        waitIdle(50);
        checkOutput("basic_done_count", ld_count, 1);
        checkStream("basic_stream", 15'h0100, 5);

        // Address wrap at the top of VRAM.
        pop_q.delete();
        ld_count = 0;
        startLine(15'h7FFE, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("wrap_addr", ram_addr, wrap_exp[i]);
            step();
        end
        waitIdle(50);
        checkOutput("wrap_done_count", ld_count, 1);
        checkStream("wrap_stream", 15'h7FFE, 4);

        // Backpressure: the fetch stops after one FIFO's worth, and a CPU write gets in.
        pixel_ready = 1'b0;
        pop_q.delete();
        ld_count = 0;
        startLine(15'h0400, 20);
        repeat (30) step();
        @(negedge clk);
        checkOutput("bp_stall_addr", ram_addr, 15'h0408);
        checkOutput("bp_busy", busy, 1);
        checkOutput("bp_valid", pixel_valid, 1);
        checkOutput("bp_head", pixel_data, golden[15'h0400]);
        step();
        cpu_write_req = 1'b1;
        cpu_addr = 15'h0200;
        cpu_data = 8'hA5;
        got = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cpu_write_ack) begin
                got = 1'b1;
                break;
            end
            step();
        end
        checkOutput("bp_cpu_ack", 32'(got), 1);
        step();
        cpu_write_req = 1'b0;
        golden[15'h0200] = 8'hA5;
        @(negedge clk);
        checkOutput("bp_addr_after_write", ram_addr, 15'h0408);
        step();
        pixel_ready = 1'b1;
        waitIdle(100);
        checkOutput("bp_done_count", ld_count, 1);
        checkStream("bp_stream", 15'h0400, 20);

        // The CPU write is visible to a later fetch.
        pop_q.delete();
        ld_count = 0;
        startLine(15'h0200, 1);
        waitIdle(20);
        checkStream("cpu_write_visible", 15'h0200, 1);

        // Restart mid-line with a read in flight.
        pop_q.delete();
        ld_count = 0;
        startLine(15'h0500, 10);
        step();
        step();
        pop_q.delete();
        ld_count = 0;
        startLine(15'h0300, 3);
        waitIdle(50);
        checkOutput("restart_done_count", ld_count, 1);
        checkStream("restart_stream", 15'h0300, 3);

        // Zero-length line.
        pop_q.delete();
        ld_count = 0;
        startLine(15'h1234, 0);
        @(negedge clk);
        checkOutput("len0_done", line_done, 1);
        checkOutput("len0_busy", busy, 0);
        checkOutput("len0_valid", pixel_valid, 0);
        step();
        @(negedge clk);
        checkOutput("len0_once", line_done, 0);
        step();
        repeat (5) step();
        checkOutput("len0_done_count", ld_count, 1);
        checkOutput("len0_no_data", pop_q.size(), 0);

        // Reset in the middle of a line.
        pixel_ready = 1'b1;
        startLine(15'h0600, 30);
        repeat (4) step();
        ld_count = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_line_done", line_done, 0);
        checkOutput("rst_mid_valid", pixel_valid, 0);
        checkOutput("rst_mid_ack", cpu_write_ack, 0);
        checkOutput("rst_mid_we", ram_write_enable, 0);
        checkOutput("rst_mid_addr", ram_addr, 0);
        checkOutput("rst_mid_data_in", ram_data_in, 0);
        step();
        pop_q.delete();
        repeat (40) step();
        @(negedge clk);
        checkOutput("rst_mid_no_done", ld_count, 0);
        checkOutput("rst_mid_no_data", pop_q.size(), 0);
        checkOutput("rst_mid_idle", busy, 0);
        step();

        // Randomised lines with backpressure and CPU traffic; the last entry reads back
        // the region the CPU wrote.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
